aes_key_sched_ctrl: RTL and testbench

//  Sequences aes_roundkey_gen through every round of one AES key expansion.
//  - Latches the cipher key and mode on a start request.
//  - Steps the generator's round index from 0 to Nr (Nr = 10/12/14 for AES-128/192/256).
//  - Waits out the generator's pipeline latency for each round.
//  - Presents each round key to the cipher core on a valid/ready stream with backpressure.
//  - Sits between the top-level AES control FSM and aes_roundkey_gen.

---
 rtl/aes_key_sched_ctrl_if.sv | 26 ++
 rtl/aes_key_sched_ctrl.sv | 138 +++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 492 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_sched_ctrl_if.sv
// Round-key stream from the key schedule controller to the cipher core.
// Valid/ready handshake; data, round and last held while stalled.
`timescale 1ns/1ps
interface aes_key_sched_ctrl_if;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_round;
    logic [127:0] rk_data;
    logic         rk_last;

    modport master (
        output rk_valid,
        output rk_round,
        output rk_data,
        output rk_last,
        input  rk_ready
    );

    modport slave (
        input  rk_valid,
        input  rk_round,
        input  rk_data,
        input  rk_last,
        output rk_ready
    );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// Steps aes_roundkey_gen through rounds 0..Nr of one key expansion and
// streams each round key out with valid/ready backpressure.
`timescale 1ns/1ps
module aes_key_sched_ctrl #(
    parameter int unsigned KG_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic [255:0]          key_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            kg_mode,
    output logic [255:0]          kg_key,
    output logic [2:0]            kg_width_sel,
    output logic [3:0]            kg_round,
    input  logic [127:0]          kg_round_key,
    aes_key_sched_ctrl_if.master  rk
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_PRESENT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [2:0] LAT = 3'(KG_LAT);

    logic [1:0] state;
    logic [2:0] wait_cnt;
    logic [3:0] nr;
    logic       accept;
    logic       last_round;

    // Nr comes from the latched mode so a live mode change cannot truncate a run
    always_comb begin
        nr = 4'd10;
        unique case (1'b1)
            kg_mode == 2'b01: nr = 4'd12;
            kg_mode == 2'b10: nr = 4'd14;
            default:          nr = 4'd10;
        endcase
    end

    assign accept       = rk.rk_valid & rk.rk_ready;
    assign last_round   = rk.rk_round == nr;
    assign busy         = state != S_IDLE;
    assign kg_width_sel = {1'b0, kg_mode};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            kg_mode     <= '0;
            kg_key      <= '0;
            kg_round    <= '0;
            rk.rk_valid <= 1'b0;
            rk.rk_round <= '0;
            rk.rk_data  <= '0;
            rk.rk_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (abort) begin
                state       <= S_IDLE;
                rk.rk_valid <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            if (mode == 2'b11) begin
                                err <= 1'b1;
                            end else begin
                                kg_mode  <= mode;
                                kg_key   <= key_in;
                                kg_round <= '0;
                                wait_cnt <= LAT;
                                state    <= S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (wait_cnt == '0) begin
                            rk.rk_data  <= kg_round_key;
                            rk.rk_round <= kg_round;
                            rk.rk_last  <= kg_round == nr;
                            rk.rk_valid <= 1'b1;
                            state       <= S_PRESENT;
                        end else begin
                            wait_cnt <= wait_cnt - 3'd1;
                        end
                    end
                    S_PRESENT: begin
                        if (accept) begin
                            rk.rk_valid <= 1'b0;
                            if (last_round) begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                kg_round <= kg_round + 4'd1;
                                wait_cnt <= LAT;
                                state    <= S_WAIT;
                            end
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    a_round_bound: assert property (
        @(posedge clk) disable iff (reset)
        kg_round <= nr
    );

    a_pulse_excl: assert property (
        @(posedge clk) disable iff (reset)
        !(done && err)
    );

    a_stall_stable: assert property (
        @(posedge clk) disable iff (reset)
        (rk.rk_valid && !rk.rk_ready && !abort)
        |=> (rk.rk_valid && $stable(rk.rk_data)
             && $stable(rk.rk_round) && $stable(rk.rk_last))
    );

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl with a behavioural round-key
// generator (real AES key expansion) behind a KG_LAT-cycle pipeline.
`timescale 1ns/1ps
module tb_aes_key_sched_ctrl;
    localparam int KG_LAT = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         abort;
    logic [1:0]   mode;
    logic [255:0] key_in;
    logic         busy;
    logic         done;
    logic         err;
    logic [1:0]   kg_mode;
    logic [255:0] kg_key;
    logic [2:0]   kg_width_sel;
    logic [3:0]   kg_round;
    logic [127:0] kg_round_key;

    aes_key_sched_ctrl_if rk_if ();

    aes_key_sched_ctrl #(.KG_LAT(KG_LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .mode         (mode),
        .key_in       (key_in),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .kg_mode      (kg_mode),
        .kg_key       (kg_key),
        .kg_width_sel (kg_width_sel),
        .kg_round     (kg_round),
        .kg_round_key (kg_round_key),
        .rk           (rk_if.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [255:0] KEY128 = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
    localparam logic [255:0] KEY192 = {64'h0, 192'h000102030405060708090a0b0c0d0e0f1011121314151617};
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    // ---------------- AES key expansion model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        if (b != 8'h00) begin
            for (int x = 1; x < 256; x++) begin
                if (gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
            end
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // key is right-aligned: first key byte at bit 32*Nk-1
    function automatic logic [127:0] get_rk(input logic [255:0] key,
                                            input logic [1:0] md, input int r);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        int nk = 4;
        int nr = 10;
        if (md == 2'b01) begin nk = 6; nr = 12; end
        if (md == 2'b10) begin nk = 8; nr = 14; end
        if (r < 0 || r > nr) return '0;
        for (int i = 0; i < nk; i++) w[i] = key[32*nk-1-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Generator: combinational expansion followed by KG_LAT (=2) register stages.
    // While rk_valid is high the output is scrambled every cycle.
    logic [127:0] gen0, gen1, gen2, noise;
    always_comb gen0 = get_rk(kg_key, kg_mode, int'(kg_round));
    always @(posedge clk) begin
        gen1  <= gen0;
        gen2  <= gen1;
        noise <= {$urandom, $urandom, $urandom, $urandom};
    end
    assign kg_round_key = gen2 ^ (rk_if.rk_valid ? noise : 128'h0);

    // ---------------- stream driver / collector ----------------
    logic [127:0] cap_data [0:15];
    logic [3:0]   cap_round [0:15];
    logic         cap_last [0:15];
    int           cap_cyc [0:15];
    int n_keys, done_cnt, stab_err, start_cyc, done_cyc, first_valid_cyc;
    bit timed_out;

    task automatic run_expand(input logic [1:0] md, input logic [255:0] k,
                              input bit stall_en);
        int wait_cnt = 0;
        bit in_key = 0;
        bit prev_stall = 0;
        logic [127:0] pd = '0;
        logic [3:0] pr = '0;
        logic pl = 1'b0;
        n_keys = 0; done_cnt = 0; stab_err = 0; timed_out = 0;
        done_cyc = -1; first_valid_cyc = -1;
        @(negedge clk);
        mode = md; key_in = k; start = 1'b1;
        rk_if.rk_ready = !stall_en;
        start_cyc = cyc;
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (prev_stall) begin
                if (!rk_if.rk_valid || rk_if.rk_data !== pd
                    || rk_if.rk_round !== pr || rk_if.rk_last !== pl)
                    stab_err++;
            end
            prev_stall = 0;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (rk_if.rk_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (!in_key) begin
                    in_key = 1;
                    wait_cnt = stall_en ? int'($urandom_range(0, 5)) : 0;
                end
                if (wait_cnt > 0) begin
                    rk_if.rk_ready = 1'b0;
                    wait_cnt--;
                    prev_stall = 1;
                    pd = rk_if.rk_data; pr = rk_if.rk_round; pl = rk_if.rk_last;
                end else begin
                    rk_if.rk_ready = 1'b1;
                    if (n_keys < 16) begin
                        cap_data[n_keys]  = rk_if.rk_data;
                        cap_round[n_keys] = rk_if.rk_round;
                        cap_last[n_keys]  = rk_if.rk_last;
                        cap_cyc[n_keys]   = cyc;
                    end
                    n_keys++;
                    in_key = 0;
                end
            end else begin
                rk_if.rk_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        if (done_cyc < 0) timed_out = 1;
        rk_if.rk_ready = 1'b1;
    endtask

    // Runs AES-128 until round 5 is presented, then leaves it stalled.
    task automatic drive_to_round5(output bit reached);
        reached = 0;
        @(negedge clk);
        mode = 2'b00; key_in = KEY128; start = 1'b1; rk_if.rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (rk_if.rk_valid && rk_if.rk_round == 4'd5) begin
                rk_if.rk_ready = 1'b0;
                reached = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00;
        key_in = '0; rk_if.rk_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, rk_if.rk_valid, rk_if.rk_last} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000",
                     {busy, done, err, rk_if.rk_valid, rk_if.rk_last});
        end
        checks++;
        if ({kg_round, rk_if.rk_round, kg_mode, kg_width_sel} !== 13'h0) begin
            errors++;
            $display("FAIL reset_idx: kg_round=%0d rk_round=%0d kg_mode=%0d width=%0d",
                     kg_round, rk_if.rk_round, kg_mode, kg_width_sel);
        end
        checks++;
        if (kg_key !== 256'h0 || rk_if.rk_data !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: kg_key=%h rk_data=%h", kg_key, rk_if.rk_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_aes128();
        logic [127:0] exp;
        run_expand(2'b00, KEY128, 1'b0);
        checks++;
        if (timed_out || n_keys !== 11) begin
            errors++;
            $display("FAIL aes128_count: got %0d keys timeout=%0d want 11", n_keys, timed_out);
        end
        for (int i = 0; i < 11 && i < n_keys; i++) begin
            exp = get_rk(KEY128, 2'b00, i);
            checks++;
            if (cap_round[i] !== 4'(i) || cap_data[i] !== exp || cap_last[i] !== (i == 10)) begin
                errors++;
                $display("FAIL aes128_key%0d: got r=%0d d=%h l=%b want r=%0d d=%h l=%b",
                         i, cap_round[i], cap_data[i], cap_last[i], i, exp, i == 10);
            end
        end
        checks++;
        if (cap_data[10] !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
            errors++;
            $display("FAIL aes128_r10: got %h want 13111d7fe3944a17f307a78b4d2b30c5", cap_data[10]);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL aes128_done: got %0d pulses want 1", done_cnt);
        end
        // cycles counted from the negedge that raises start
        checks++;
        if (first_valid_cyc - start_cyc !== KG_LAT + 2) begin
            errors++;
            $display("FAIL aes128_first_lat: got %0d want %0d",
                     first_valid_cyc - start_cyc, KG_LAT + 2);
        end
        checks++;
        if (done_cyc - start_cyc !== 45) begin
            errors++;
            $display("FAIL aes128_done_lat: got %0d want 45", done_cyc - start_cyc);
        end
        for (int i = 1; i < 11 && i < n_keys; i++) begin
            checks++;
            if (cap_cyc[i] - cap_cyc[i-1] !== KG_LAT + 2) begin
                errors++;
                $display("FAIL aes128_rate%0d: got %0d want %0d",
                         i, cap_cyc[i] - cap_cyc[i-1], KG_LAT + 2);
            end
        end
        checks++;
        if (busy !== 1'b0 || kg_width_sel !== 3'b000) begin
            errors++;
            $display("FAIL aes128_idle: busy=%b width=%0d want 0 0", busy, kg_width_sel);
        end
    endtask

    task automatic test_aes192();
        int bad = 0;
        run_expand(2'b01, KEY192, 1'b0);
        checks++;
        if (timed_out || n_keys !== 13 || done_cnt !== 1) begin
            errors++;
            $display("FAIL aes192_count: got %0d keys %0d done want 13 1", n_keys, done_cnt);
        end
        for (int i = 0; i < 13 && i < n_keys; i++)
            if (cap_round[i] !== 4'(i) || cap_data[i] !== get_rk(KEY192, 2'b01, i)
                || cap_last[i] !== (i == 12)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL aes192_keys: got %0d bad keys want 0", bad);
        end
        checks++;
        if (cap_data[12] !== 128'ha4970a331a78dc09c418c271e3a41d5d) begin
            errors++;
            $display("FAIL aes192_r12: got %h want a4970a331a78dc09c418c271e3a41d5d", cap_data[12]);
        end
        checks++;
        if (kg_width_sel !== 3'b001) begin
            errors++;
            $display("FAIL aes192_width: got %0d want 1", kg_width_sel);
        end
    endtask

    task automatic test_aes256();
        int bad = 0;
        run_expand(2'b10, KEY256, 1'b0);
        checks++;
        if (timed_out || n_keys !== 15 || done_cnt !== 1) begin
            errors++;
            $display("FAIL aes256_count: got %0d keys %0d done want 15 1", n_keys, done_cnt);
        end
        for (int i = 0; i < 15 && i < n_keys; i++)
            if (cap_round[i] !== 4'(i) || cap_data[i] !== get_rk(KEY256, 2'b10, i)
                || cap_last[i] !== (i == 14)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL aes256_keys: got %0d bad keys want 0", bad);
        end
        checks++;
        if (cap_data[1] !== 128'h101112131415161718191a1b1c1d1e1f) begin
            errors++;
            $display("FAIL aes256_r1: got %h want 101112131415161718191a1b1c1d1e1f", cap_data[1]);
        end
        checks++;
        if (cap_data[14] !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin
            errors++;
            $display("FAIL aes256_r14: got %h want 24fc79ccbf0979e9371ac23c6d68de36", cap_data[14]);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        run_expand(2'b00, KEY128, 1'b1);
        checks++;
        if (timed_out || n_keys !== 11 || done_cnt !== 1) begin
            errors++;
            $display("FAIL bp_count: got %0d keys %0d done want 11 1", n_keys, done_cnt);
        end
        checks++;
        if (stab_err !== 0) begin
            errors++;
            $display("FAIL bp_stable: got %0d unstable stall cycles want 0", stab_err);
        end
        for (int i = 0; i < 11 && i < n_keys; i++)
            if (cap_round[i] !== 4'(i) || cap_data[i] !== get_rk(KEY128, 2'b00, i)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_keys: got %0d bad keys want 0", bad);
        end
    endtask

    task automatic test_illegal_mode();
        int seen = 0;
        @(negedge clk);
        mode = 2'b11; key_in = KEY128; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || rk_if.rk_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_err: err=%b busy=%b valid=%b want 1 0 0",
                     err, busy, rk_if.rk_valid);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse: err=%b want 0", err);
        end
        repeat (6) begin
            @(negedge clk);
            if (busy || rk_if.rk_valid || err) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL illegal_quiet: got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_start_busy();
        @(negedge clk);
        mode = 2'b00; key_in = KEY128; start = 1'b1; rk_if.rk_ready = 1'b0;
        @(negedge clk);
        mode = 2'b10; key_in = KEY256;
        repeat (8) @(negedge clk);
        start = 1'b0;
        checks++;
        if (kg_mode !== 2'b00 || kg_key !== KEY128) begin
            errors++;
            $display("FAIL start_busy: kg_mode=%0d kg_key=%h want 0 and key128", kg_mode, kg_key);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        rk_if.rk_ready = 1'b1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_busy_abort: busy=%b want 0", busy);
        end
    endtask

    task automatic test_abort();
        bit reached;
        int bad = 0;
        drive_to_round5(reached);
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL abort_reach: round 5 not presented within budget");
        end
        abort = 1'b1;
        rk_if.rk_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || rk_if.rk_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b valid=%b done=%b want 0 0 0",
                     busy, rk_if.rk_valid, done);
        end
        checks++;
        if (rk_if.rk_data !== get_rk(KEY128, 2'b00, 5) || kg_round !== 4'd5) begin
            errors++;
            $display("FAIL abort_hold: rk_data=%h kg_round=%0d want round5 key and 5",
                     rk_if.rk_data, kg_round);
        end
        run_expand(2'b00, KEY128, 1'b0);
        for (int i = 0; i < 11 && i < n_keys; i++)
            if (cap_round[i] !== 4'(i) || cap_data[i] !== get_rk(KEY128, 2'b00, i)) bad++;
        checks++;
        if (timed_out || n_keys !== 11 || bad !== 0 || done_cnt !== 1) begin
            errors++;
            $display("FAIL abort_rerun: keys=%0d bad=%0d done=%0d want 11 0 1",
                     n_keys, bad, done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit reached;
        int bad = 0;
        drive_to_round5(reached);
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL rstmid_reach: round 5 not presented within budget");
        end
        reset = 1'b1;
        rk_if.rk_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({busy, done, rk_if.rk_valid, rk_if.rk_last} !== 4'b0
            || rk_if.rk_data !== 128'h0 || kg_round !== 4'd0 || kg_key !== 256'h0) begin
            errors++;
            $display("FAIL rstmid_state: busy=%b valid=%b data=%h kg_round=%0d want all zero",
                     busy, rk_if.rk_valid, rk_if.rk_data, kg_round);
        end
        run_expand(2'b00, KEY128, 1'b0);
        for (int i = 0; i < 11 && i < n_keys; i++)
            if (cap_round[i] !== 4'(i) || cap_data[i] !== get_rk(KEY128, 2'b00, i)) bad++;
        checks++;
        if (timed_out || n_keys !== 11 || bad !== 0 || done_cnt !== 1) begin
            errors++;
            $display("FAIL rstmid_rerun: keys=%0d bad=%0d done=%0d want 11 0 1",
                     n_keys, bad, done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_backpressure();
        test_illegal_mode();
        test_start_busy();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
